// File: rtl/axi_read_burst_gen_if.sv
// AXI read-address / read-data channel bundle between a read master and its slave.
// Ports (modport master = traffic generator side, slave = responder side):
//   ar_*  : address channel fields, ar_valid (master->slave), ar_ready (slave->master)
//   r_*   : data channel fields, r_valid (slave->master), r_ready (master->slave)
interface axi_read_burst_gen_if #(
    parameter int unsigned TIDW  = 1,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 64,
    parameter int unsigned USERW = 1
);
    logic [TIDW-1:0]  ar_id;
    logic [AW-1:0]    ar_addr;
    logic [7:0]       ar_len;
    logic [2:0]       ar_size;
    logic [1:0]       ar_burst;
    logic             ar_lock;
    logic [3:0]       ar_cache;
    logic [2:0]       ar_prot;
    logic [3:0]       ar_qos;
    logic [3:0]       ar_region;
    logic [USERW-1:0] ar_user;
    logic             ar_valid;
    logic             ar_ready;

    logic [TIDW-1:0]  r_id;
    logic [DW-1:0]    r_data;
    logic [1:0]       r_resp;
    logic             r_last;
    logic [USERW-1:0] r_user;
    logic             r_valid;
    logic             r_ready;

    modport master (
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_read_burst_gen.sv
// AXI read traffic master: issues a programmed run of INCR read bursts with rolling
// IDs and a bounded number of bursts in flight, checks the returning R stream for
// protocol errors and reports status counters.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; latches num_txn/base_addr/burst_len and begins a run (IDLE/DONE only)
//   num_txn           bursts to issue in the run
//   base_addr         address of the first burst
//   burst_len         ARLEN used for every burst
//   bus               AXI AR/R master port
//   busy / done       run in progress / run finished
//   err_cnt           saturating count of R-channel protocol errors in this run
//   beat_cnt          wrapping count of R beats accepted in this run
module axi_read_burst_gen #(
    parameter int unsigned TIDW      = 1,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 64,
    parameter int unsigned USERW     = 1,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          num_txn,
    input  logic [AW-1:0]        base_addr,
    input  logic [7:0]           burst_len,
    axi_read_burst_gen_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_cnt,
    output logic [31:0]          beat_cnt
);
    localparam int unsigned NID   = 1 << TIDW;
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned OW    = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [15:0]         num_txn_q, num_txn_d;
    logic [7:0]          len_q, len_d;
    logic [AW-1:0]       stride_q, stride_d;
    logic [AW-1:0]       next_addr_q, next_addr_d;
    logic [15:0]         issued_q, issued_d;
    logic [OW-1:0]       outst_q, outst_d;
    logic [NID-1:0][7:0] bc_q, bc_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [31:0]         beat_cnt_q, beat_cnt_d;
    logic                ar_valid_q, ar_valid_d;
    logic [TIDW-1:0]     ar_id_q, ar_id_d;
    logic [AW-1:0]       ar_addr_q, ar_addr_d;
    logic [7:0]          ar_len_q, ar_len_d;
    logic [2:0]          ar_size_q, ar_size_d;
    logic [1:0]          ar_burst_q, ar_burst_d;
    logic                r_ready_q, r_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic ar_hs, r_hs, beat_err, outst_dec;

    // Read data and user sideband are accepted but not inspected.
    logic unused_r;
    assign unused_r = ^{bus.r_data, bus.r_user};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_txn_q   <= '0;
            len_q       <= '0;
            stride_q    <= '0;
            next_addr_q <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            bc_q        <= '0;
            err_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            ar_valid_q  <= 1'b0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            ar_burst_q  <= '0;
            r_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_txn_q   <= num_txn_d;
            len_q       <= len_d;
            stride_q    <= stride_d;
            next_addr_q <= next_addr_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            bc_q        <= bc_d;
            err_cnt_q   <= err_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            ar_burst_q  <= ar_burst_d;
            r_ready_q   <= r_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, R checking, outstanding tracking and AR request generation.
    always_comb begin
        state_d     = state_q;
        num_txn_d   = num_txn_q;
        len_d       = len_q;
        stride_d    = stride_q;
        next_addr_d = next_addr_q;
        issued_d    = issued_q;
        outst_d     = outst_q;
        bc_d        = bc_q;
        err_cnt_d   = err_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        ar_valid_d  = ar_valid_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        beat_err    = 1'b0;
        outst_dec   = 1'b0;

        ar_hs = ar_valid_q & bus.ar_ready;
        r_hs  = bus.r_valid & r_ready_q;

        // bc tracks beats received so far of the open burst on each ID.
        if (r_hs) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            beat_err   = (bus.r_resp != 2'b00)
                       || ( bus.r_last && (bc_q[bus.r_id] != len_q))
                       || (!bus.r_last && (bc_q[bus.r_id] == len_q))
                       || (outst_q == '0);
            if (bus.r_last) begin
                bc_d[bus.r_id] = '0;
                // An orphan RLAST closes nothing.
                outst_dec      = (outst_q != '0);
            end else begin
                bc_d[bus.r_id] = bc_q[bus.r_id] + 8'd1;
            end
            if (beat_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        outst_d = outst_q + OW'(ar_hs) - OW'(outst_dec);

        if (ar_hs) begin
            issued_d    = issued_q + 16'd1;
            next_addr_d = next_addr_q + stride_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    num_txn_d   = num_txn;
                    len_d       = burst_len;
                    stride_d    = AW'((32'(burst_len) + 32'd1) << SIZE);
                    next_addr_d = base_addr;
                    issued_d    = '0;
                    outst_d     = '0;
                    bc_d        = '0;
                    err_cnt_d   = '0;
                    beat_cnt_d  = '0;
                end
            end
            S_RUN: begin
                if (num_txn_q == 16'd0) begin
                    state_d = S_DONE;
                end else if (issued_d == num_txn_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A presented request is held unchanged until accepted; otherwise the
        // next request may go out on the cycle right after a handshake.
        if (!(ar_valid_q && !bus.ar_ready)) begin
            ar_valid_d = (state_q == S_RUN) && (state_d == S_RUN)
                       && (issued_d < num_txn_q)
                       && (outst_d < OW'(MAX_OUTST));
            if (ar_valid_d) begin
                ar_id_d    = issued_d[TIDW-1:0];
                ar_addr_d  = next_addr_d;
                ar_len_d   = len_q;
                ar_size_d  = 3'(SIZE);
                ar_burst_d = 2'b01;
            end
        end

        r_ready_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
    end

    assign bus.ar_valid  = ar_valid_q;
    assign bus.ar_id     = ar_id_q;
    assign bus.ar_addr   = ar_addr_q;
    assign bus.ar_len    = ar_len_q;
    assign bus.ar_size   = ar_size_q;
    assign bus.ar_burst  = ar_burst_q;
    assign bus.ar_lock   = 1'b0;
    assign bus.ar_cache  = 4'd0;
    assign bus.ar_prot   = 3'd0;
    assign bus.ar_qos    = 4'd0;
    assign bus.ar_region = 4'd0;
    assign bus.ar_user   = {USERW{1'b0}};
    assign bus.r_ready   = r_ready_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_axi_read_burst_gen.sv
// Bench for axi_read_burst_gen: AXI slave model with configurable AR back-pressure and
// R fault injection, AR scoreboard filled from the address rule, counters checked per run.
`timescale 1ns/1ps
module tb_axi_read_burst_gen;
    localparam int unsigned TIDW      = 1;
    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 64;
    localparam int unsigned USERW     = 1;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned BYTES     = DW / 8;

    typedef struct {
        logic [TIDW-1:0] id;
        logic [AW-1:0]   addr;
        logic [7:0]      len;
    } ar_t;

    typedef struct {
        logic [TIDW-1:0] id;
        logic            last;
        logic [1:0]      resp;
        logic            err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_txn = '0;
    logic [31:0] base_addr = '0;
    logic [7:0]  burst_len = '0;
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [31:0] beat_cnt;

    axi_read_burst_gen_if #(.TIDW(TIDW), .AW(AW), .DW(DW), .USERW(USERW)) bus ();

    axi_read_burst_gen #(
        .TIDW(TIDW), .AW(AW), .DW(DW), .USERW(USERW), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn),
        .base_addr(base_addr), .burst_len(burst_len), .bus(bus),
        .busy(busy), .done(done), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    ar_t   exp_ar_q[$];
    ar_t   acc_q[$];
    beat_t beat_q[$];
    beat_t cur_beat;
    bit    r_taken = 0, ar_taken = 0, r_hold = 0;
    int    exp_beats = 0, exp_err = 0, ar_hs_run = 0, model_outst = 0;
    int    ar_mode = 0, fault_mode = 0, r_gap_pct = 0, burst_no = 0, stall_ctr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expand one accepted AR into its R beats, possibly with a protocol fault.
    task automatic gen_burst(input ar_t a);
        int    l, nb, kind, bad_k, k;
        beat_t b;
        l = int'(a.len);
        kind = 0;
        nb = l + 1;
        bad_k = -1;
        if (fault_mode == 1) begin
            if (burst_no == 0) kind = 1;
            else if (burst_no == 1) kind = 3;
        end else if (fault_mode == 2) begin
            if ($urandom_range(0, 9) < 3) kind = int'($urandom_range(1, 3));
        end
        if (kind == 1 && l == 0) kind = 0;
        if (kind == 1) nb = (fault_mode == 1) ? 3 : int'($urandom_range(0, l - 1)) + 1;
        if (kind == 2) nb = l + 2;
        if (kind == 3) bad_k = (fault_mode == 1) ? 1 : int'($urandom_range(0, l));
        for (k = 0; k < nb; k++) begin
            b.id   = a.id;
            b.last = (k == nb - 1);
            b.resp = (k == bad_k) ? ((fault_mode == 1) ? 2'b10 : 2'($urandom_range(1, 3))) : 2'b00;
            b.err  = (b.resp != 2'b00) || (b.last && k != l) || (!b.last && k == l);
            beat_q.push_back(b);
        end
        burst_no++;
    endtask

    // Slave driver: updates inputs just after each rising edge.
    initial begin
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_id     = '0;
        bus.r_data   = '0;
        bus.r_resp   = '0;
        bus.r_last   = 1'b0;
        bus.r_user   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.r_valid = 1'b0;
                r_taken = 0;
                ar_taken = 0;
                stall_ctr = 0;
                acc_q.delete();
                beat_q.delete();
            end else begin
                if (r_taken) begin
                    r_taken = 0;
                    bus.r_valid = 1'b0;
                end
                while (acc_q.size() > 0) gen_burst(acc_q.pop_front());
                if (!bus.r_valid && !r_hold && beat_q.size() > 0
                    && int'($urandom_range(0, 99)) >= r_gap_pct) begin
                    cur_beat    = beat_q.pop_front();
                    bus.r_id    = cur_beat.id;
                    bus.r_last  = cur_beat.last;
                    bus.r_resp  = cur_beat.resp;
                    bus.r_data  = {$urandom, $urandom};
                    bus.r_user  = USERW'($urandom);
                    bus.r_valid = 1'b1;
                end
                if (ar_taken) begin
                    ar_taken = 0;
                    stall_ctr = 0;
                end
                if (bus.ar_valid) stall_ctr++;
                case (ar_mode)
                    0:       bus.ar_ready = 1'b1;
                    1:       bus.ar_ready = 1'($urandom_range(0, 1));
                    default: bus.ar_ready = (stall_ctr > 5);
                endcase
            end
        end
    end

    // Monitor: on the falling edge, valid&ready means a handshake at the next rising edge.
    logic        pv_valid = 1'b0, pv_ready = 1'b0;
    logic [45:0] pv_fields = '0;
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_valid = 1'b0;
            end else begin
                if (pv_valid && !pv_ready) begin
                    check("ar_hold_valid", 64'(bus.ar_valid), 64'd1);
                    check("ar_hold_fields",
                          64'({bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst}),
                          64'(pv_fields));
                end
                if (bus.r_valid && bus.r_ready) begin
                    exp_beats++;
                    if (cur_beat.err) exp_err++;
                    if (cur_beat.last && model_outst > 0) model_outst--;
                    r_taken = 1;
                end
                if (bus.ar_valid && bus.ar_ready) begin
                    ar_hs_run++;
                    if (exp_ar_q.size() == 0) begin
                        check("ar_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_ar_q.pop_front();
                        check("ar_id", 64'(bus.ar_id), 64'(e.id));
                        check("ar_addr", 64'(bus.ar_addr), 64'(e.addr));
                        check("ar_len", 64'(bus.ar_len), 64'(e.len));
                        check("ar_size", 64'(bus.ar_size), 64'd3);
                        check("ar_burst", 64'(bus.ar_burst), 64'd1);
                        check("ar_attrs", 64'({bus.ar_lock, bus.ar_cache, bus.ar_prot,
                                               bus.ar_qos, bus.ar_region, bus.ar_user}), 64'd0);
                    end
                    acc_q.push_back('{id: bus.ar_id, addr: bus.ar_addr, len: bus.ar_len});
                    ar_taken = 1;
                    model_outst++;
                    check("outst_bound", 64'(model_outst <= int'(MAX_OUTST)), 64'd1);
                end
                pv_valid  = bus.ar_valid;
                pv_ready  = bus.ar_ready;
                pv_fields = {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst};
            end
        end
    end

    task automatic start_run(input int n, input logic [31:0] base, input int len,
                             input int mode, input int fmode, input int gap);
        ar_mode = mode;
        fault_mode = fmode;
        r_gap_pct = gap;
        burst_no = 0;
        exp_beats = 0;
        exp_err = 0;
        ar_hs_run = 0;
        model_outst = 0;
        for (int i = 0; i < n; i++) begin
            exp_ar_q.push_back('{id: TIDW'(i),
                                 addr: base + 32'(i) * 32'(len + 1) * 32'(BYTES),
                                 len: 8'(len)});
        end
        @(posedge clk);
        #2;
        start = 1'b1;
        num_txn = 16'(n);
        base_addr = base;
        burst_len = 8'(len);
        @(posedge clk);
        #2;
        start = 1'b0;
        num_txn = 16'($urandom);
        base_addr = $urandom;
        burst_len = 8'($urandom);
    endtask

    task automatic finish_run(input string name, input int n);
        int cyc;
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_r_ready"}, 64'(bus.r_ready), 64'd0);
        check({name, "_ar_valid"}, 64'(bus.ar_valid), 64'd0);
        check({name, "_beat_cnt"}, 64'(beat_cnt), 64'(exp_beats));
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({name, "_ar_count"}, 64'(ar_hs_run), 64'(n));
        check({name, "_ar_left"}, 64'(exp_ar_q.size()), 64'd0);
        check({name, "_r_left"}, 64'(beat_q.size() + int'(bus.r_valid)), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ar_valid", 64'(bus.ar_valid), 64'd0);
        check("rst_r_ready", 64'(bus.r_ready), 64'd0);
        check("rst_counters", 64'({err_cnt, beat_cnt}), 64'd0);
        check("rst_ar_fields", 64'({bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst}), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Basic run: addresses 0x1000/0x1020/0x1040/0x1060, IDs 0,1,0,1.
        start_run(4, 32'h1000, 3, 0, 0, 0);
        finish_run("basic", 4);
        check("basic_beats16", 64'(beat_cnt), 64'd16);
        check("basic_err0", 64'(err_cnt), 64'd0);

        // Outstanding limit with R withheld.
        r_hold = 1;
        start_run(8, 32'h2000, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("outst_ar_count", 64'(ar_hs_run), 64'd4);
        check("outst_ar_valid_low", 64'(bus.ar_valid), 64'd0);
        r_hold = 0;
        finish_run("outst", 8);

        // AR stalled 5 cycles per request; a start while busy must be ignored.
        start_run(3, 32'h3000, 2, 2, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        num_txn = 16'd9;
        base_addr = 32'hDEAD_0000;
        burst_len = 8'd5;
        @(posedge clk);
        #2;
        start = 1'b0;
        finish_run("stall", 3);

        // Early RLAST on burst 0 and one SLVERR beat in burst 1.
        start_run(2, 32'h4000, 3, 0, 1, 0);
        finish_run("fault", 2);
        check("fault_err2", 64'(err_cnt), 64'd2);

        // Zero-length run completes one cycle after start.
        start_run(0, 32'h5000, 1, 0, 0, 0);
        check("zero_busy_run", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        check("zero_done_next", 64'(done), 64'd1);
        finish_run("zero", 0);

        // Address wrap at the top of the address space.
        start_run(2, 32'hFFFF_FFF0, 1, 0, 0, 0);
        finish_run("wrap", 2);

        // Orphan beat accepted before any AR is outstanding.
        beat_q.push_back('{id: '0, last: 1'b1, resp: 2'b00, err: 1'b1});
        start_run(1, 32'h6000, 1, 2, 0, 0);
        finish_run("orphan", 1);
        check("orphan_err1", 64'(err_cnt), 64'd1);

        // Reset during DRAIN.
        r_hold = 1;
        start_run(2, 32'h7000, 3, 0, 0, 0);
        repeat (10) @(negedge clk);
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_ar_count", 64'(ar_hs_run), 64'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_ar_valid", 64'(bus.ar_valid), 64'd0);
        check("mid_rst_r_ready", 64'(bus.r_ready), 64'd0);
        check("mid_rst_counters", 64'({err_cnt, beat_cnt}), 64'd0);
        exp_ar_q.delete();
        model_outst = 0;
        r_hold = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        start_run(3, 32'h8000, 2, 0, 0, 0);
        finish_run("post_rst", 3);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            int n, len;
            n = int'($urandom_range(1, 12));
            len = int'($urandom_range(0, 7));
            start_run(n, $urandom, len, int'($urandom_range(0, 2)), 2, int'($urandom_range(0, 50)));
            finish_run("rand", n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
